button_debounce: RTL and testbench
==================================

# button_debounce

Multi-channel front-end conditioner for raw board push-buttons. Synchronises each asynchronous button input, applies polarity correction and a stable-time debounce, and emits a clean debounced level plus single-cycle press, release and auto-repeat strobes. Sits directly upstream of the press-counting / LED display logic, which consumes `press` instead of edge-detecting a raw pin.

## Interface
- `N_BTN`, 4, number of independent button channels.
- `ACTIVE_LOW`, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥1.
- `HOLD_CYCLES`, 25000000, cycles a press must persist before the first repeat strobe; must be ≥1.
- `REPEAT_CYCLES`, 5000000, period of subsequent repeat strobes; must be ≥1.
- `clk  in  1  system clock.`
- `rst  in  1  reset: synchronous, active-high.`
- `btn_in  in  N_BTN  raw asynchronous button pins.`
- `level  out  N_BTN  debounced state, 1 = pressed.`
- `press  out  N_BTN  one-cycle strobe when level goes 0→1.`
- `release  out  N_BTN  one-cycle strobe when level goes 1→0.`
- `repeat  out  N_BTN  one-cycle auto-repeat strobe while held.`

## Operation
- Per channel: 2-flop synchroniser, then XOR with `ACTIVE_LOW` to give `s` (1 = pressed).
- Debounce counter `dcnt`: increments each cycle `s != level`; cleared to 0 any cycle `s == level` (any bounce restarts the count). When `s != level` and `dcnt == DEBOUNCE_CYCLES-1`: `level` toggles at that edge, `dcnt` clears, and `press` or `release` is high for exactly the cycle in which the new `level` is first visible.
- Channel FSM: IDLE (level 0) → PRESSED on accepted press; PRESSED → HELD when `hcnt` reaches `HOLD_CYCLES-1` (fires `repeat`); HELD fires `repeat` every `REPEAT_CYCLES`; PRESSED or HELD → IDLE on accepted release (fires `release`, no `repeat` in the same cycle).
- Hold counter `hcnt` cleared on press strobe and on each repeat strobe; counts only in PRESSED/HELD.
- Counter widths: `$clog2` of the largest relevant parameter, minimum 1; no counter wraps (always cleared before overflow).
- Channels are fully independent; simultaneous events on different channels all reported in the same cycle.
- `press`, `release`, `repeat` are never asserted together on one channel.

## Timing
- Reset (`rst` high at a `clk` edge): synchroniser flops load the not-pressed pin level, `level`=0, `press`=`release`=`repeat`=0, all counters 0, FSM IDLE. Outputs valid the cycle after.
- `rst` mid-debounce or mid-hold aborts silently: no `release` is emitted for a channel pressed at reset.
- Button held through reset: treated as a new press; `press` fires `DEBOUNCE_CYCLES+2` cycles after `rst` deasserts.
- Latency: first `clk` edge sampling a new stable pin value = edge 0; `level`/strobe change at edge `DEBOUNCE_CYCLES+2`.
- First `repeat`: `HOLD_CYCLES` cycles after the `press` cycle; subsequent ones every `REPEAT_CYCLES` cycles.
- All outputs registered; no combinational path from `btn_in`.

## Structure
- Package `btn_pkg`: channel state enum (`BTN_IDLE`, `BTN_PRESSED`, `BTN_HELD`) and a counter-width helper function.
- Sub-module `btn_channel`: synchroniser, debounce counter, hold counter and FSM for one button; top generates `N_BTN` instances and concatenates outputs.

## Test plan
Use `N_BTN`=2, `ACTIVE_LOW`=1, `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=10, `REPEAT_CYCLES`=3.
- Clean press: `btn_in[0]` 1→0 held → `press[0]` single pulse and `level[0]`=1 at edge 6; `release[0]` single pulse at edge 6 after returning to 1.
- Bounce: `btn_in[0]` toggles 0,1,0 at 1-cycle spacing then stays 0 → exactly one `press[0]`, 6 cycles after the final transition.
- Glitch: 3-cycle low pulse on `btn_in[1]` → no `level`/`press`/`release` change.
- Hold: press held 20 cycles after `press` → `repeat[0]` at +10, +13, +16, +19; release → `release`, no further `repeat`.
- Simultaneous: both pins pressed same cycle → `press`=2'b11 in one cycle.
- Reset: `rst` pulsed while channel 0 in HELD with pin still low → outputs 0 during reset, no `release`; `press[0]` 6 cycles after `rst` falls.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
//   btn_state_e : per-channel sequencing state
//   cnt_width   : bits needed for a counter that runs 0 .. max_count-1
//   max2        : larger of two integers, for sizing a shared counter
package btn_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_PRESSED = 2'd1,
    BTN_HELD    = 2'd2
  } btn_state_e;

  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, polarity fix, stable-time
// debounce, and press/hold/auto-repeat sequencing.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   i_btn         raw asynchronous pin
//   o_level       debounced level, 1 = pressed
//   o_press       one-cycle strobe with the first cycle of level = 1
//   o_release     one-cycle strobe with the first cycle of level = 0
//   o_repeat      one-cycle auto-repeat strobe while held
module btn_channel
  import btn_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int   DW       = cnt_width(DEBOUNCE_CYCLES);
  localparam int   HW       = cnt_width(max2(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic POL      = (ACTIVE_LOW != 0);
  // Pin level that means "not pressed"; the synchroniser resets to it so a
  // button held through reset is seen as a fresh press.
  localparam logic IDLE_PIN = POL;

  logic          r_sync1, r_sync2;
  logic          r_s;
  logic          r_lvl;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt;
  btn_state_e    r_state, w_next;
  logic          r_press, r_release, r_repeat;

  logic w_accept, w_press_ev, w_release_ev, w_repeat_ev;

  // r_s is a registered copy of the polarity-corrected sample; this stage
  // lines the level change up with edge DEBOUNCE_CYCLES+2.
  assign w_accept     = (r_s != r_lvl) && (r_dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign w_press_ev   = w_accept && !r_lvl;
  assign w_release_ev = w_accept &&  r_lvl;

  always_ff @(posedge clk) begin
    if (rst) r_state <= BTN_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_repeat_ev = 1'b0;
    case (r_state)
      BTN_IDLE: begin
        if (w_press_ev) w_next = BTN_PRESSED;
      end
      BTN_PRESSED: begin
        if (w_release_ev) begin
          w_next = BTN_IDLE;
        end else if (r_hcnt == HW'(HOLD_CYCLES - 1)) begin
          w_next      = BTN_HELD;
          w_repeat_ev = 1'b1;
        end
      end
      BTN_HELD: begin
        if (w_release_ev) w_next = BTN_IDLE;
        else if (r_hcnt == HW'(REPEAT_CYCLES - 1)) w_repeat_ev = 1'b1;
      end
      default: w_next = BTN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= IDLE_PIN;
      r_sync2   <= IDLE_PIN;
      r_s       <= 1'b0;
      r_lvl     <= 1'b0;
      r_dcnt    <= '0;
      r_hcnt    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_s     <= r_sync2 ^ POL;

      if (w_accept) begin
        r_lvl  <= ~r_lvl;
        r_dcnt <= '0;
      end else if (r_s != r_lvl) begin
        r_dcnt <= r_dcnt + DW'(1);
      end else begin
        r_dcnt <= '0;
      end

      if (w_press_ev || w_repeat_ev || (w_next == BTN_IDLE)) r_hcnt <= '0;
      else                                                  r_hcnt <= r_hcnt + HW'(1);

      r_press   <= w_press_ev;
      r_release <= w_release_ev;
      r_repeat  <= w_repeat_ev;
    end
  end

  assign o_level   = r_lvl;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner: one independent btn_channel per pin.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   i_btn_in      raw asynchronous button pins
//   o_level       debounced levels, 1 = pressed
//   o_press       per-channel press strobes
//   o_release     per-channel release strobes
//   o_repeat      per-channel auto-repeat strobes
module button_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn_in,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_repeat
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_btn     (i_btn_in[g]),
      .o_level   (o_level[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_repeat  (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with a history-based reference:
// a level change is accepted once the last DEBOUNCE_CYCLES synchronised
// samples all disagree with the current level; repeats fall at
// press + HOLD + k*REPEAT while the level stays high.
module tb_button_debounce;

  localparam int NB   = 2;
  localparam int AL   = 1;
  localparam int D    = 4;
  localparam int H    = 10;
  localparam int R    = 3;
  localparam int MAXC = 6000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '1;
  logic [NB-1:0] o_level, o_press, o_release, o_repeat;

  button_debounce #(
    .N_BTN(NB), .ACTIVE_LOW(AL), .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .rst(rst), .i_btn_in(btn),
    .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_repeat(o_repeat)
  );

  always #5 clk = ~clk;

  int n = -1;
  int checks = 0;
  int passed = 0;
  bit h_rst [MAXC];
  bit h_p   [NB][MAXC];
  bit m_level [NB];
  int m_tp    [NB];
  logic [NB-1:0] e_level, e_press, e_rel, e_rep;

  // Polarity-corrected value that reached the decision point after edge m.
  function automatic bit s_after(int c, int m);
    if (h_rst[m] || h_rst[m-1]) return 1'b0;
    return h_p[c][m-2];
  endfunction

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, n);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, n);
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    n++;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget observed=%0d expected<%0d", n, MAXC);
      $fatal(1);
    end
    h_rst[n] = rst;
    for (int c = 0; c < NB; c++)
      h_p[c][n] = rst ? 1'b0 : ((AL != 0) ? ~btn[c] : btn[c]);
    e_press = '0; e_rel = '0; e_rep = '0;
    for (int c = 0; c < NB; c++) begin
      if (rst) begin
        m_level[c] = 1'b0;
      end else begin
        acc = (n >= D + 2);
        if (acc)
          for (int m = n - D; m < n; m++)
            if (s_after(c, m) == m_level[c]) acc = 1'b0;
        if (acc) begin
          if (!m_level[c]) begin
            e_press[c] = 1'b1; m_level[c] = 1'b1; m_tp[c] = n;
          end else begin
            e_rel[c] = 1'b1; m_level[c] = 1'b0;
          end
        end else if (m_level[c] && (n - m_tp[c] >= H) && ((n - m_tp[c] - H) % R == 0)) begin
          e_rep[c] = 1'b1;
        end
      end
      e_level[c] = m_level[c];
    end
    #1;
    chk("level",   o_level,   e_level);
    chk("press",   o_press,   e_press);
    chk("release", o_release, e_rel);
    chk("repeat",  o_repeat,  e_rep);
  endtask

  // kind 0 = press, 1 = release; idx = ticks until the strobe (-1 if none)
  task automatic wait_ev(input int kind, input int c, output int idx);
    idx = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((kind == 0 && o_press[c]) || (kind == 1 && o_release[c])) begin
        idx = i;
        break;
      end
    end
  endtask

  initial begin
    int idx, cnt, gap;
    rst = 1'b1; btn = '1;
    repeat (3) tick();
    chk("reset_outputs", o_level | o_press | o_release | o_repeat, '0);
    rst = 1'b0;
    repeat (5) tick();

    // clean press / release on channel 0
    btn[0] = 1'b0;
    wait_ev(0, 0, idx); chk_int("clean_press_latency", idx, D + 2);
    repeat (3) tick();
    btn[0] = 1'b1;
    wait_ev(1, 0, idx); chk_int("clean_release_latency", idx, D + 2);
    repeat (4) tick();

    // bounce 0,1,0 then stable low
    btn[0] = 1'b0; tick();
    btn[0] = 1'b1; tick();
    btn[0] = 1'b0;
    wait_ev(0, 0, idx); chk_int("bounce_press_latency", idx, D + 2);
    btn[0] = 1'b1;
    wait_ev(1, 0, idx); chk_int("bounce_release_latency", idx, D + 2);
    repeat (4) tick();

    // 3-cycle glitch on channel 1
    cnt = 0;
    btn[1] = 1'b0;
    repeat (3) begin tick(); cnt += o_press[1] + o_level[1]; end
    btn[1] = 1'b1;
    repeat (12) begin tick(); cnt += o_press[1] + o_level[1] + o_release[1]; end
    chk_int("glitch_no_event", cnt, 0);

    // hold with auto-repeat
    btn[0] = 1'b0;
    wait_ev(0, 0, idx); chk_int("hold_press_latency", idx, D + 2);
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (o_repeat[0]) begin
        gap = (i < H) ? -1 : ((i - H) % R);
        chk_int("repeat_position", gap, 0);
        cnt++;
      end
    end
    chk_int("repeat_count", cnt, 4);
    btn[0] = 1'b1;
    wait_ev(1, 0, idx); chk_int("hold_release_latency", idx, D + 2);
    cnt = 0;
    repeat (15) begin tick(); cnt += o_repeat[0]; end
    chk_int("no_repeat_after_release", cnt, 0);

    // simultaneous press
    btn = '0;
    wait_ev(0, 0, idx);
    chk("simultaneous_press", o_press, 2'b11);
    repeat (H + 4) tick();

    // reset while held, pin still low
    rst = 1'b1;
    cnt = 0;
    repeat (2) begin tick(); cnt += o_release[0] + o_level[0] + o_repeat[0]; end
    chk_int("reset_silent", cnt, 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt += o_release[0];
      if (o_press[0]) begin idx = i; break; end
      idx = -1;
    end
    chk_int("press_after_reset_latency", idx, D + 2);
    chk_int("no_release_after_reset", cnt, 0);
    btn = '1;
    repeat (10) tick();

    // randomized phases: fast bouncing, then slower with long holds, rare resets
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range((i < 700) ? 6 : 40) == 0) btn[c] = ~btn[c];
      rst = ($urandom_range(250) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
